// File: rtl/bus_arbiter_pkg.sv
// Shared types and bus widths for the memory bus arbiter.
// The width constants are also used by the cpu core so both agree on the bus shape.
package bus_arbiter_pkg;

   localparam int BUS_ADDRESS_WIDTH = 16;
   localparam int BUS_DATA_WIDTH    = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RESPOND = 2'd2
   } arbiter_state_t;

   typedef struct packed {
      logic                         pending;
      logic                         write;
      logic [BUS_ADDRESS_WIDTH-1:0] address;
      logic [BUS_DATA_WIDTH-1:0]    data;
   } request_slot_t;

   // A one-requester system still needs a one-bit index.
   function automatic int index_width(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester-side and memory-side signals of the bus arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface bus_arbiter_if
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 2,
   parameter int ADDRESS_WIDTH  = BUS_ADDRESS_WIDTH,
   parameter int DATA_WIDTH     = BUS_DATA_WIDTH
) ();

   logic [NUM_REQUESTERS-1:0][ADDRESS_WIDTH-1:0] req_address_i;
   logic [NUM_REQUESTERS-1:0]                    req_address_valid_i;
   logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]    req_data_i;
   logic [NUM_REQUESTERS-1:0]                    req_data_valid_i;

   logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0]    rsp_data_o;
   logic [NUM_REQUESTERS-1:0]                    rsp_data_valid_o;
   logic [NUM_REQUESTERS-1:0]                    rsp_done_o;
   logic [NUM_REQUESTERS-1:0]                    overrun_o;
   logic                                         timeout_o;

   logic [ADDRESS_WIDTH-1:0]                     mem_address_o;
   logic [DATA_WIDTH-1:0]                        mem_write_data_o;
   logic                                         mem_write_o;
   logic                                         mem_request_o;
   logic [DATA_WIDTH-1:0]                        mem_read_data_i;
   logic                                         mem_ack_i;

   modport slave (
      input  req_address_i,
      input  req_address_valid_i,
      input  req_data_i,
      input  req_data_valid_i,
      output rsp_data_o,
      output rsp_data_valid_o,
      output rsp_done_o,
      output overrun_o,
      output timeout_o,
      output mem_address_o,
      output mem_write_data_o,
      output mem_write_o,
      output mem_request_o,
      input  mem_read_data_i,
      input  mem_ack_i
   );

   modport master (
      output req_address_i,
      output req_address_valid_i,
      output req_data_i,
      output req_data_valid_i,
      input  rsp_data_o,
      input  rsp_data_valid_o,
      input  rsp_done_o,
      input  overrun_o,
      input  timeout_o,
      input  mem_address_o,
      input  mem_write_data_o,
      input  mem_write_o,
      input  mem_request_o,
      output mem_read_data_i,
      output mem_ack_i
   );

endinterface

// File: rtl/bus_arbiter_round_robin_picker.sv
// Combinational round-robin choice: the first pending requester after the
// last one granted, wrapping around, so a busy requester cannot starve others.
module round_robin_picker
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 2,
   parameter int INDEX_WIDTH    = index_width(NUM_REQUESTERS)
) (
   input  logic [NUM_REQUESTERS-1:0] pending_mask,
   input  logic [INDEX_WIDTH-1:0]    last_grant,
   output logic                      grant_valid,
   output logic [INDEX_WIDTH-1:0]    grant_index
);

   // Walk from the farthest candidate to the nearest so the nearest pending one wins.
   always_comb begin
      int candidate;
      grant_valid = 1'b0;
      grant_index = '0;
      candidate   = 0;
      for (int offset = NUM_REQUESTERS; offset >= 1; offset--) begin
         candidate = (int'(last_grant) + offset) % NUM_REQUESTERS;
         if (pending_mask[candidate]) begin
            grant_valid = 1'b1;
            grant_index = INDEX_WIDTH'(candidate);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one single-port memory bus between several pulse-style masters:
// latches each request in a slot, grants round-robin and returns completion pulses.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int                    NUM_REQUESTERS = 2,
   parameter int                    ADDRESS_WIDTH  = BUS_ADDRESS_WIDTH,
   parameter int                    DATA_WIDTH     = BUS_DATA_WIDTH,
   parameter int                    TIMEOUT_CYCLES = 64,
   parameter logic [DATA_WIDTH-1:0] OPEN_BUS_VALUE = 8'hFF
) (
   input logic          clock_i,
   input logic          reset_i,
   bus_arbiter_if.slave bus
);

   localparam int INDEX_WIDTH = index_width(NUM_REQUESTERS);
   localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   arbiter_state_t state, state_next;

   request_slot_t                             slots [NUM_REQUESTERS];
   logic [NUM_REQUESTERS-1:0]                 pending_mask;
   logic [NUM_REQUESTERS-1:0]                 slot_release;

   logic                                      grant_valid;
   logic [INDEX_WIDTH-1:0]                    grant_index;
   logic [INDEX_WIDTH-1:0]                    last_grant;

   logic                                      load_grant;
   logic                                      access_acked;
   logic                                      access_timed_out;
   logic [TIMER_WIDTH-1:0]                    timeout_count;
   logic [DATA_WIDTH-1:0]                     completion_data;

   logic [ADDRESS_WIDTH-1:0]                  mem_address_q;
   logic [DATA_WIDTH-1:0]                     mem_write_data_q;
   logic                                      mem_write_q;
   logic                                      mem_request_q;

   logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] rsp_data_q;
   logic [NUM_REQUESTERS-1:0]                 rsp_data_valid_q;
   logic [NUM_REQUESTERS-1:0]                 rsp_done_q;
   logic [NUM_REQUESTERS-1:0]                 overrun_q;
   logic                                      timeout_q;

   // The slot being answered is released on the RESPOND edge, so a fresh pulse
   // from the same requester on that edge lands in the freed slot.
   always_comb begin
      pending_mask = '0;
      slot_release = '0;
      for (int n = 0; n < NUM_REQUESTERS; n++) begin
         pending_mask[n] = slots[n].pending;
         slot_release[n] = (state == RESPOND) && (last_grant == INDEX_WIDTH'(n));
      end
   end

   round_robin_picker #(
      .NUM_REQUESTERS (NUM_REQUESTERS),
      .INDEX_WIDTH    (INDEX_WIDTH)
   ) picker (
      .pending_mask (pending_mask),
      .last_grant   (last_grant),
      .grant_valid  (grant_valid),
      .grant_index  (grant_index)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // An ack in the same cycle the timer expires still counts as a normal completion.
   always_comb begin
      state_next       = state;
      load_grant       = 1'b0;
      access_acked     = 1'b0;
      access_timed_out = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) begin
               load_grant = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.mem_ack_i && mem_request_q) begin
               access_acked = 1'b1;
               state_next   = RESPOND;
            end else if (timeout_count == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
               access_timed_out = 1'b1;
               state_next       = RESPOND;
            end
         end
         RESPOND: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign completion_data = access_acked ? bus.mem_read_data_i : OPEN_BUS_VALUE;

   // Memory port, response pulses and request slots all move on one clock edge.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int n = 0; n < NUM_REQUESTERS; n++) begin
            slots[n] <= '0;
         end
         last_grant       <= INDEX_WIDTH'(NUM_REQUESTERS - 1);
         timeout_count    <= '0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         mem_write_q      <= 1'b0;
         mem_request_q    <= 1'b0;
         rsp_data_q       <= '0;
         rsp_data_valid_q <= '0;
         rsp_done_q       <= '0;
         overrun_q        <= '0;
         timeout_q        <= 1'b0;
      end else begin
         rsp_data_valid_q <= '0;
         rsp_done_q       <= '0;

         if (load_grant) begin
            last_grant       <= grant_index;
            mem_address_q    <= ADDRESS_WIDTH'(slots[grant_index].address);
            mem_write_data_q <= DATA_WIDTH'(slots[grant_index].data);
            mem_write_q      <= slots[grant_index].write;
            mem_request_q    <= 1'b1;
            timeout_count    <= '0;
         end

         if (state == ISSUE && !access_acked && !access_timed_out) begin
            timeout_count <= timeout_count + 1'b1;
         end

         if (access_acked || access_timed_out) begin
            mem_request_q          <= 1'b0;
            rsp_done_q[last_grant] <= 1'b1;
            if (!mem_write_q) begin
               rsp_data_valid_q[last_grant] <= 1'b1;
               rsp_data_q[last_grant]       <= completion_data;
            end
         end

         if (access_timed_out) begin
            timeout_q <= 1'b1;
         end

         for (int n = 0; n < NUM_REQUESTERS; n++) begin
            if (bus.req_address_valid_i[n]) begin
               if (!slots[n].pending || slot_release[n]) begin
                  slots[n] <= '{pending: 1'b1,
                                write:   bus.req_data_valid_i[n],
                                address: BUS_ADDRESS_WIDTH'(bus.req_address_i[n]),
                                data:    BUS_DATA_WIDTH'(bus.req_data_i[n])};
               end else begin
                  overrun_q[n] <= 1'b1;
               end
            end else if (slot_release[n]) begin
               slots[n].pending <= 1'b0;
            end
         end
      end
   end

   assign bus.mem_address_o    = mem_address_q;
   assign bus.mem_write_data_o = mem_write_data_q;
   assign bus.mem_write_o      = mem_write_q;
   assign bus.mem_request_o    = mem_request_q;
   assign bus.rsp_data_o       = rsp_data_q;
   assign bus.rsp_data_valid_o = rsp_data_valid_q;
   assign bus.rsp_done_o       = rsp_done_q;
   assign bus.overrun_o        = overrun_q;
   assign bus.timeout_o        = timeout_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares one single-port memory/peripheral bus between NUM_REQUESTERS masters (requester 0 = cpu, requester 1 = PPU/DMA).
Each requester uses the same pulse-style interface the cpu core drives: an address_valid pulse, plus a data_valid pulse for writes.
The arbiter latches each request, grants the memory port round-robin and holds the memory handshake until acknowledged or timed out. It then returns a completion pulse, and read data for reads, to the owning requester.
Sits between the masters and the board memory controller in toplevel.

Parameters:
NUM_REQUESTERS, 2, number of masters; legal range 2..4.
ADDRESS_WIDTH, 16, bus address width.
DATA_WIDTH, 8, bus data width.
TIMEOUT_CYCLES, 64, maximum cycles mem_request_o stays high without mem_ack_i before the access is aborted.
OPEN_BUS_VALUE, 8'hFF, read data returned on a timed-out read.

Ports:
clock_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
req_address_i  in  NUM_REQUESTERS x ADDRESS_WIDTH  request address per requester
req_address_valid_i  in  NUM_REQUESTERS  one-cycle request pulse
req_data_i  in  NUM_REQUESTERS x DATA_WIDTH  write data
req_data_valid_i  in  NUM_REQUESTERS  write qualifier; sampled only with req_address_valid_i
rsp_data_o  out  NUM_REQUESTERS x DATA_WIDTH  read data
rsp_data_valid_o  out  NUM_REQUESTERS  one-cycle pulse; read completed
rsp_done_o  out  NUM_REQUESTERS  one-cycle pulse; any access (read or write) completed
overrun_o  out  NUM_REQUESTERS  sticky; request dropped because a slot was already pending
timeout_o  out  1  sticky; an access timed out
mem_address_o  out  ADDRESS_WIDTH  memory address
mem_write_data_o  out  DATA_WIDTH  memory write data
mem_write_o  out  1  1 = write, 0 = read; valid while mem_request_o
mem_request_o  out  1  held high until mem_ack_i
mem_read_data_i  in  DATA_WIDTH  valid in the cycle mem_ack_i is high (reads)
mem_ack_i  in  1  access complete; ignored unless mem_request_o is high

Behaviour:
- Reset: all pending slots cleared, FSM = IDLE, round-robin pointer = last index (so requester 0 wins first).
- Reset values: mem_request_o=0, mem_write_o=0, mem_address_o=0, mem_write_data_o=0, every rsp_*=0, overrun_o=0, timeout_o=0.
- Reset mid-access: the memory access is abandoned, no response is ever issued, and mem_request_o=0 on the cycle after reset is sampled.
- Request capture:
  - req_address_valid_i[n] high at a clock edge with slot n empty: the slot latches address, data and write=req_data_valid_i[n].
  - If slot n is full, the request is dropped and overrun_o[n] is set.
  - Slot n frees in the same cycle its response pulses; a new request on that edge is accepted, with no overrun.
- FSM:
  - IDLE: if any slot is pending, pick the first pending index after the pointer (mod N), update the pointer, load the mem_* registers and go to ISSUE. mem_request_o is high from the next cycle.
  - ISSUE: hold mem_request_o and all mem_* outputs stable. On mem_ack_i, capture mem_read_data_i and go to RESPOND.
  - ISSUE, no ack: the timeout counter increments each cycle. At TIMEOUT_CYCLES without ack, drop mem_request_o, set timeout_o, substitute OPEN_BUS_VALUE for a read, and go to RESPOND.
  - RESPOND (1 cycle): mem_request_o=0; pulse rsp_done_o[g], and rsp_data_valid_o[g] with rsp_data_o[g] if the access was a read. Clear slot g, go to IDLE.
- rsp_data_o[n] holds its last value between pulses.
- Latency: request pulse in cycle 0 -> mem_request_o high in cycle 2. mem_ack_i in cycle k -> response pulse in cycle k+1, mem_request_o low in cycle k+1.
- Back-to-back: the earliest next mem_request_o is 2 cycles after RESPOND, so there is a 1-cycle IDLE gap.
- Simultaneous requests in one cycle: served in round-robin order; no requester is starved while others keep requesting.
- The timeout counter is wide enough for TIMEOUT_CYCLES and resets on entry to ISSUE.

Decomposition:
- Package bus_arbiter_pkg:
  - arbiter_state_t enum {IDLE, ISSUE, RESPOND};
  - request_slot_t struct {pending, write, address, data};
  - BUS_ADDRESS_WIDTH=16 and BUS_DATA_WIDTH=8 constants, shared with cpu.
- Sub-module round_robin_picker: combinational. Inputs are a pending mask and the last-grant pointer; outputs are grant_valid and grant_index.

Test Plan:
1. Read: req 0 reads 16'h8000. Memory acks after 3 cycles with 8'h5A -> mem_request_o high cycles 2-4, mem_write_o=0; rsp_data_valid_o[0] and rsp_done_o[0] pulse in cycle 5 with rsp_data_o[0]=8'h5A.
2. Write: req 1 writes 8'h3C to 16'h2007 with ack in the first cycle -> mem_write_o=1, mem_write_data_o=8'h3C held until ack; rsp_done_o[1] pulses; rsp_data_valid_o[1] stays 0.
3. Contention: both requesters pulse in the same cycle, twice in a row after completion -> grant order 0,1,0,1; both complete, no overrun.
4. Overrun: req 0 pulses 16'h0001, then pulses 16'h0002 while the first is still pending -> only 16'h0001 reaches mem_address_o; overrun_o[0]=1 and stays set.
5. Timeout: read with mem_ack_i never asserted, TIMEOUT_CYCLES=8 -> mem_request_o drops after 8 cycles; rsp_data_o=8'hFF with a valid pulse; timeout_o=1.
6. Reset mid-ISSUE: assert reset_i while mem_request_o=1 -> the next cycle has mem_request_o=0 and no rsp pulse. A new read after reset is served by requester 0 first.
